issue_hazard_ctrl: RTL and testbench

// - Issue controller between the decode pipe register and execute. Decides each cycle whether the decoded instr may issue.
// - Per-register pending-write scoreboard detects RAW hazards; stalls decode while a source register is pending.
// - Sequences multi-cycle M-extension ops (start/done handshake); flushes fetch/decode on execute redirects.

---
 rtl/issue_hazard_ctrl_if.sv | 39 +++
 rtl/issue_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_issue_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/issue_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | issue_hazard_ctrl_if : decode/writeback/execute signals of the issue ctrl  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface issue_hazard_ctrl_if;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic [4:0] dec_rd;
  logic       dec_we;
  logic       dec_mop;
  logic       wb_we;
  logic [4:0] wb_rd;
  logic       ex_redirect;
  logic       md_done;
  logic       issue;
  logic       stall_dec;
  logic       kill_dec;
  logic       flush;
  logic       md_start;
  logic       md_abort;
  logic       md_err;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_we, dec_mop,
    output wb_we, wb_rd, ex_redirect, md_done,
    input  issue, stall_dec, kill_dec, flush, md_start, md_abort, md_err
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_we, dec_mop,
    input  wb_we, wb_rd, ex_redirect, md_done,
    output issue, stall_dec, kill_dec, flush, md_start, md_abort, md_err
  );
endinterface
`default_nettype wire

// File: rtl/issue_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | issue_hazard_ctrl : RAW scoreboard, M-op sequencing and redirect flushing  |
// | Optional: HAZ_WB_BYPASS_EN lets a source retiring in writeback issue now.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module issue_hazard_ctrl #(
  parameter int NREG         = 32,
  parameter int CNT_W        = 2,
  parameter int REDIRECT_CYC = 2,
  parameter int MD_MAX_CYC   = 64
) (
  input  logic                clk,
  input  logic                rst,
  issue_hazard_ctrl_if.slave  bus
);

  typedef logic [4:0] reg_addr_t;
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MD_BUSY  = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam int              c_rc_w   = (REDIRECT_CYC > 2) ? $clog2(REDIRECT_CYC) : 1;
  localparam int              c_wd_w   = $clog2(MD_MAX_CYC + 2);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t              r_state, w_state_nxt;
  logic [c_rc_w-1:0]   r_rc, w_rc_nxt;
  logic [c_wd_w-1:0]   r_wd;
  reg_addr_t           r_md_rd;
  logic                r_md_we;
  logic                r_md_err;
  logic [CNT_W-1:0]    r_cnt     [NREG];
  logic [CNT_W-1:0]    w_cnt_nxt [NREG];

  logic [CNT_W-1:0]    w_cnt_rs1, w_cnt_rs2, w_cnt_rd;
  logic                w_byp1, w_byp2, w_raw, w_sat;
  logic                w_issue, w_md_start, w_md_abort;
  logic                w_inc, w_dwb, w_dab;
  logic [CNT_W:0]      w_sum;
  logic [1:0]          w_sub;

  // Scoreboard lookup; the loop starts at 1 so x0 always reads as free.
  always_comb begin
    w_cnt_rs1 = '0;
    w_cnt_rs2 = '0;
    w_cnt_rd  = '0;
    for (int i = 1; i < NREG; i++) begin
      if (bus.dec_rs1 == reg_addr_t'(i)) w_cnt_rs1 = r_cnt[i];
      if (bus.dec_rs2 == reg_addr_t'(i)) w_cnt_rs2 = r_cnt[i];
      if (bus.dec_rd  == reg_addr_t'(i)) w_cnt_rd  = r_cnt[i];
    end
  end

  always_comb begin
`ifdef HAZ_WB_BYPASS_EN
    w_byp1 = bus.wb_we & (bus.wb_rd == bus.dec_rs1) & (w_cnt_rs1 == CNT_W'(1));
    w_byp2 = bus.wb_we & (bus.wb_rd == bus.dec_rs2) & (w_cnt_rs2 == CNT_W'(1));
`else
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
`endif
    w_raw = (bus.dec_use_rs1 & (bus.dec_rs1 != '0) & (w_cnt_rs1 != '0) & ~w_byp1) |
            (bus.dec_use_rs2 & (bus.dec_rs2 != '0) & (w_cnt_rs2 != '0) & ~w_byp2);
    w_sat = bus.dec_we & (bus.dec_rd != '0) & (w_cnt_rd == c_cnt_max);
  end

  // FSM next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = r_rc;
    w_issue     = ~rst & bus.dec_valid & (r_state == S_RUN) & ~bus.ex_redirect & ~w_raw & ~w_sat;
    w_md_start  = w_issue & bus.dec_mop;
    // A result arriving with the redirect retires normally, so nothing to abort.
    w_md_abort  = ~rst & bus.ex_redirect & (r_state == S_MD_BUSY) & ~bus.md_done;

    case (r_state)
      S_RUN:      if (w_md_start) w_state_nxt = S_MD_BUSY;
      S_MD_BUSY:  if (bus.md_done) w_state_nxt = S_RUN;
      S_REDIRECT: begin
        if (r_rc == c_rc_w'(REDIRECT_CYC - 1)) w_state_nxt = S_RUN;
        else                                   w_rc_nxt    = r_rc + 1'b1;
      end
      default:    w_state_nxt = S_RUN;
    endcase

    // The redirect cycle itself is the first killed cycle, so the hold counter resumes at 1.
    if (bus.ex_redirect) begin
      w_state_nxt = (REDIRECT_CYC > 1) ? S_REDIRECT : S_RUN;
      w_rc_nxt    = c_rc_w'(1);
    end
  end

  always_comb begin
    w_inc = 1'b0;
    w_dwb = 1'b0;
    w_dab = 1'b0;
    w_sum = '0;
    w_sub = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = '0;
    end
    for (int i = 1; i < NREG; i++) begin
      w_inc = w_issue & bus.dec_we & (bus.dec_rd == reg_addr_t'(i));
      w_dwb = bus.wb_we & (bus.wb_rd == reg_addr_t'(i));
      w_dab = w_md_abort & r_md_we & (r_md_rd == reg_addr_t'(i));
      w_sum = {1'b0, r_cnt[i]} + {{CNT_W{1'b0}}, w_inc};
      w_sub = {1'b0, w_dwb} + {1'b0, w_dab};
      // Saturation blocks issue at max, so w_sum never overflows CNT_W bits.
      w_cnt_nxt[i] = ((CNT_W + 1)'(w_sub) >= w_sum) ? '0 : CNT_W'(w_sum - (CNT_W + 1)'(w_sub));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_rc     <= '0;
      r_wd     <= '0;
      r_md_rd  <= '0;
      r_md_we  <= 1'b0;
      r_md_err <= 1'b0;
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rc    <= w_rc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_md_start) begin
        r_md_rd <= bus.dec_rd;
        r_md_we <= bus.dec_we;
        r_wd    <= c_wd_w'(1);
      end else if (r_state == S_MD_BUSY) begin
        if (r_wd != c_wd_w'(MD_MAX_CYC + 1)) r_wd <= r_wd + 1'b1;
        if (r_wd >= c_wd_w'(MD_MAX_CYC))     r_md_err <= 1'b1;
      end
    end
  end

  assign bus.issue     = w_issue;
  assign bus.flush     = bus.ex_redirect;
  assign bus.stall_dec = bus.dec_valid & ~w_issue & ~bus.ex_redirect;
  assign bus.kill_dec  = ~w_issue & (bus.dec_valid | bus.ex_redirect | (r_state == S_REDIRECT));
  assign bus.md_start  = w_md_start;
  assign bus.md_abort  = w_md_abort;
  assign bus.md_err    = r_md_err;

endmodule
`default_nettype wire

// File: tb/tb_issue_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_issue_hazard_ctrl : directed vectors for issue_hazard_ctrl              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_issue_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  issue_hazard_ctrl_if bus ();

  issue_hazard_ctrl #(
    .NREG(32), .CNT_W(2), .REDIRECT_CYC(2), .MD_MAX_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr();
    bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_use_rs1 = 0;
    bus.dec_use_rs2 = 0; bus.dec_rd = 0; bus.dec_we = 0; bus.dec_mop = 0;
    bus.wb_we = 0; bus.wb_rd = 0; bus.ex_redirect = 0; bus.md_done = 0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we, input logic mop);
    bus.dec_valid = 1; bus.dec_rs1 = rs1; bus.dec_use_rs1 = u1; bus.dec_rs2 = rs2;
    bus.dec_use_rs2 = u2; bus.dec_rd = rd; bus.dec_we = we; bus.dec_mop = mop;
  endtask

  task automatic do_reset();
    clr(); rst = 1; cyc(); cyc(); rst = 0;
  endtask

  initial begin
    clr(); rst = 1;
    // Reset
    settle(); cyc(); settle();
    check_eq("rst_issue", bus.issue, 0);
    check_eq("rst_stall", bus.stall_dec, 0);
    check_eq("rst_kill", bus.kill_dec, 0);
    check_eq("rst_md_err", bus.md_err, 0);
    cyc(); rst = 0;
    dec(3, 1, 0, 0, 0, 0, 0); settle();
    check_eq("rst_first_issue", bus.issue, 1);
    check_eq("rst_first_nostall", bus.stall_dec, 0);
    cyc();

    // RAW on x5 cleared by writeback in cycle 4
    do_reset();
    dec(0, 0, 0, 0, 5, 1, 0); settle();
    check_eq("raw_producer_issue", bus.issue, 1);
    cyc();
    dec(5, 1, 0, 0, 6, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      settle();
      check_eq("raw_stall", bus.stall_dec, 1);
      check_eq("raw_no_issue", bus.issue, 0);
      cyc();
    end
    bus.wb_we = 1; bus.wb_rd = 5; settle();
`ifdef HAZ_WB_BYPASS_EN
    check_eq("raw_wb_issue_byp", bus.issue, 1);
    check_eq("raw_wb_nostall_byp", bus.stall_dec, 0);
    cyc();
`else
    check_eq("raw_wb_no_issue", bus.issue, 0);
    check_eq("raw_wb_stall", bus.stall_dec, 1);
    cyc();
    bus.wb_we = 0; settle();
    check_eq("raw_after_wb_issue", bus.issue, 1);
    cyc();
`endif

    // x0 is never tracked
    do_reset();
    dec(0, 0, 0, 0, 0, 1, 0); settle();
    check_eq("x0_wr_issue", bus.issue, 1);
    cyc();
    dec(0, 1, 0, 1, 1, 0, 0); settle();
    check_eq("x0_rd_issue", bus.issue, 1);
    check_eq("x0_rd_nostall", bus.stall_dec, 0);
    cyc();

    // Redirect, then redirect restart inside REDIRECT
    do_reset();
    dec(1, 1, 0, 0, 2, 0, 0); bus.ex_redirect = 1; settle();
    check_eq("redir_flush", bus.flush, 1);
    check_eq("redir_kill0", bus.kill_dec, 1);
    check_eq("redir_no_issue0", bus.issue, 0);
    check_eq("redir_nostall0", bus.stall_dec, 0);
    cyc();
    bus.ex_redirect = 0; settle();
    check_eq("redir_flush_once", bus.flush, 0);
    check_eq("redir_kill1", bus.kill_dec, 1);
    check_eq("redir_stall1", bus.stall_dec, 1);
    cyc(); settle();
    check_eq("redir_issue2", bus.issue, 1);
    check_eq("redir_nokill2", bus.kill_dec, 0);
    cyc();
    bus.ex_redirect = 1; settle(); cyc();
    settle();
    check_eq("redir_again_flush", bus.flush, 1);
    cyc();
    bus.ex_redirect = 0; settle();
    check_eq("redir_restart_kill", bus.kill_dec, 1);
    check_eq("redir_restart_noissue", bus.issue, 0);
    cyc(); settle();
    check_eq("redir_restart_issue", bus.issue, 1);
    cyc();

    // M op rd=9, md_done at cycle 20, watchdog limit 16
    do_reset();
    dec(0, 0, 0, 0, 9, 1, 1); settle();
    check_eq("md_issue", bus.issue, 1);
    check_eq("md_start", bus.md_start, 1);
    cyc();
    dec(3, 1, 0, 0, 4, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) bus.md_done = 1;
      settle();
      check_eq("md_busy_stall", bus.stall_dec, 1);
      if (c == 1)  check_eq("md_start_pulse", bus.md_start, 0);
      if (c == 16) check_eq("md_err_c16", bus.md_err, 0);
      if (c == 17) check_eq("md_err_c17", bus.md_err, 1);
      cyc();
    end
    bus.md_done = 0; settle();
    check_eq("md_run_issue", bus.issue, 1);
    check_eq("md_err_sticky", bus.md_err, 1);
    cyc();
    dec(9, 1, 0, 0, 4, 0, 0); settle();
    check_eq("md_rd9_pending", bus.stall_dec, 1);
    cyc();
    do_reset(); settle();
    check_eq("md_err_cleared", bus.md_err, 0);

    // Redirect aborts M op and releases its scoreboard entry
    do_reset();
    dec(0, 0, 0, 0, 9, 1, 1); settle(); cyc();
    dec(9, 1, 0, 0, 4, 0, 0); settle(); cyc();
    settle(); cyc();
    bus.ex_redirect = 1; settle();
    check_eq("abort_pulse", bus.md_abort, 1);
    check_eq("abort_flush", bus.flush, 1);
    cyc();
    bus.ex_redirect = 0; settle();
    check_eq("abort_once", bus.md_abort, 0);
    check_eq("abort_kill", bus.kill_dec, 1);
    cyc(); settle();
    check_eq("abort_cnt_released", bus.issue, 1);
    cyc();

    // md_done with redirect: no abort, rd stays pending until writeback
    do_reset();
    dec(0, 0, 0, 0, 9, 1, 1); settle(); cyc();
    dec(9, 1, 0, 0, 4, 0, 0); settle(); cyc();
    bus.md_done = 1; bus.ex_redirect = 1; settle();
    check_eq("done_redir_no_abort", bus.md_abort, 0);
    check_eq("done_redir_flush", bus.flush, 1);
    cyc();
    bus.md_done = 0; bus.ex_redirect = 0; settle(); cyc();
    settle();
    check_eq("done_redir_cnt_kept", bus.stall_dec, 1);
    cyc();
    bus.wb_we = 1; bus.wb_rd = 9; settle();
`ifdef HAZ_WB_BYPASS_EN
    check_eq("done_redir_wb_byp", bus.issue, 1);
`else
    check_eq("done_redir_wb_wait", bus.issue, 0);
`endif
    cyc();
    bus.wb_we = 0;

    // Saturation of x7 counter
    do_reset();
    dec(0, 0, 0, 0, 7, 1, 0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("sat_fill_issue", bus.issue, 1);
      cyc();
    end
    settle();
    check_eq("sat_stall", bus.stall_dec, 1);
    check_eq("sat_no_issue", bus.issue, 0);
    cyc();
    bus.wb_we = 1; bus.wb_rd = 7; settle();
    check_eq("sat_wb_cycle", bus.issue, 0);
    cyc();
    bus.wb_we = 0; settle();
    check_eq("sat_release", bus.issue, 1);
    cyc();

    // Reset in the middle of an M op
    do_reset();
    dec(0, 0, 0, 0, 9, 1, 1); settle(); cyc();
    dec(9, 1, 0, 0, 4, 0, 0); settle(); cyc();
    rst = 1; bus.ex_redirect = 1; settle();
    check_eq("rst_mid_no_abort", bus.md_abort, 0);
    cyc();
    rst = 0; bus.ex_redirect = 0; settle();
    check_eq("rst_mid_cleared", bus.issue, 1);
    check_eq("rst_mid_err", bus.md_err, 0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
